// File: rtl/tlb_walk_controller.sv
// Single-level page-table walker that refills the TLB on a miss.
// Two miss sources (port 0 = fetch, port 1 = load/store) share one walk engine.
// The engine arbitrates them round-robin, reads one PTE, then either fills the
// TLB or reports a page fault. Only one walk is in flight at a time.
//
// Optional build macro: TLB_WALK_PERF_CNT_EN
//   When defined, adds o_walk_count / o_fault_count, two saturating 16-bit
//   counters of started walks and faulted walks.
//
// PTE layout: bit 0 = valid, bits [PA_WIDTH:1] = PPN, upper bits ignored.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | no walk; grant a pending requester and latch vpn/PTE address
// REQ    | PTE read outstanding, o_mem_req held until i_mem_ack
// FILL   | one-cycle TLB write strobe with the latched vpn/ppn
// RESP   | one-cycle done pulse to the granted port, flip rr pointer

module tlb_walk_controller #(
   parameter int VA_WIDTH       = 20,
   parameter int PA_WIDTH       = 20,
   parameter int MEM_ADDR_WIDTH = 32,
   parameter int PTE_WIDTH      = 32
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      i_ptbr_we,
   input  logic [MEM_ADDR_WIDTH-1:0] i_ptbr,
   input  logic [1:0]                i_req_valid,
   input  logic [2*VA_WIDTH-1:0]     i_req_vpn,
   output logic [1:0]                o_req_done,
   output logic                      o_req_fault,
   output logic                      o_mem_req,
   output logic [MEM_ADDR_WIDTH-1:0] o_mem_addr,
   input  logic                      i_mem_ack,
   input  logic [PTE_WIDTH-1:0]      i_mem_rdata,
   output logic                      o_tlb_write_enable,
   output logic [VA_WIDTH-1:0]       o_tlb_write_virtual_addr,
   output logic [PA_WIDTH-1:0]       o_tlb_write_physical_addr,
   output logic                      o_busy
`ifdef TLB_WALK_PERF_CNT_EN
   ,
   output logic [15:0]               o_walk_count,
   output logic [15:0]               o_fault_count
`endif
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_FILL = 2'd2,
      S_RESP = 2'd3
   } state_t;

   state_t                    r_state;
   logic [MEM_ADDR_WIDTH-1:0] r_ptbr;
   logic [MEM_ADDR_WIDTH-1:0] r_mem_addr;
   logic                      r_rr;
   logic                      r_grant;
   logic [VA_WIDTH-1:0]       r_vpn;
   logic [PA_WIDTH-1:0]       r_ppn;
   logic                      r_mem_req;
   logic                      r_tlb_we;
   logic [1:0]                r_done;
   logic                      r_fault_out;
   logic                      r_busy;

   logic                      w_grant;
   logic [VA_WIDTH-1:0]       w_sel_vpn;
   logic [MEM_ADDR_WIDTH-1:0] w_pte_addr;
   logic                      w_pte_valid;
   logic [PA_WIDTH-1:0]       w_pte_ppn;
   logic                      w_unused_rdata;

   // On a tie the rr pointer decides; otherwise the lone requester wins.
   assign w_grant    = (i_req_valid == 2'b11) ? r_rr : i_req_valid[1];
   assign w_sel_vpn  = w_grant ? i_req_vpn[2*VA_WIDTH-1:VA_WIDTH] : i_req_vpn[VA_WIDTH-1:0];
   // Wraps silently at MEM_ADDR_WIDTH; uses the registered ptbr, so a ptbr
   // write in the grant cycle only affects the next walk.
   assign w_pte_addr = r_ptbr + MEM_ADDR_WIDTH'({w_sel_vpn, 2'b00});

   assign w_pte_valid    = i_mem_rdata[0];
   assign w_pte_ppn      = i_mem_rdata[PA_WIDTH:1];
   assign w_unused_rdata = ^i_mem_rdata;

   // Page-table base register, writable at any time.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptbr <= '0;
      end else if (i_ptbr_we) begin
         r_ptbr <= i_ptbr;
      end
   end

   // Walk FSM with all outputs registered alongside the state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_rr        <= 1'b0;
         r_grant     <= 1'b0;
         r_vpn       <= '0;
         r_ppn       <= '0;
         r_mem_addr  <= '0;
         r_mem_req   <= 1'b0;
         r_tlb_we    <= 1'b0;
         r_done      <= 2'b00;
         r_fault_out <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_tlb_we    <= 1'b0;
         r_done      <= 2'b00;
         r_fault_out <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (|i_req_valid) begin
                  r_grant    <= w_grant;
                  r_vpn      <= w_sel_vpn;
                  r_mem_addr <= w_pte_addr;
                  r_mem_req  <= 1'b1;
                  r_busy     <= 1'b1;
                  r_state    <= S_REQ;
               end
            end
            S_REQ: begin
               if (i_mem_ack) begin
                  r_mem_req <= 1'b0;
                  if (w_pte_valid) begin
                     r_ppn    <= w_pte_ppn;
                     r_tlb_we <= 1'b1;
                     r_state  <= S_FILL;
                  end else begin
                     r_done      <= r_grant ? 2'b10 : 2'b01;
                     r_fault_out <= 1'b1;
                     r_state     <= S_RESP;
                  end
               end
            end
            S_FILL: begin
               r_done  <= r_grant ? 2'b10 : 2'b01;
               r_state <= S_RESP;
            end
            S_RESP: begin
               r_rr    <= ~r_grant;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_mem_req <= 1'b0;
               r_busy    <= 1'b0;
               r_state   <= S_IDLE;
            end
         endcase
      end
   end

   assign o_req_done                = r_done;
   assign o_req_fault               = r_fault_out;
   assign o_mem_req                 = r_mem_req;
   assign o_mem_addr                = r_mem_addr;
   assign o_tlb_write_enable        = r_tlb_we;
   assign o_tlb_write_virtual_addr  = r_vpn;
   assign o_tlb_write_physical_addr = r_ppn;
   assign o_busy                    = r_busy;

`ifdef TLB_WALK_PERF_CNT_EN
   logic [15:0] r_walk_count;
   logic [15:0] r_fault_count;

   // Saturating counters of started walks and faulted walks.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_walk_count  <= '0;
         r_fault_count <= '0;
      end else begin
         if ((r_state == S_IDLE) && (|i_req_valid) && (r_walk_count != 16'hFFFF)) begin
            r_walk_count <= r_walk_count + 16'd1;
         end
         if ((r_state == S_RESP) && r_fault_out && (r_fault_count != 16'hFFFF)) begin
            r_fault_count <= r_fault_count + 16'd1;
         end
      end
   end

   assign o_walk_count  = r_walk_count;
   assign o_fault_count = r_fault_count;
`endif

endmodule

// File: tb/tb_tlb_walk_controller.sv
// Self-checking bench for tlb_walk_controller (default build).
// A transaction-level model tracks pending requesters, the rr winner, ptbr and
// the expected PTE address / fill / fault outcome of each walk.

module tb_tlb_walk_controller;

   logic        clk;
   logic        rst_n;
   logic        i_ptbr_we;
   logic [31:0] i_ptbr;
   logic [1:0]  i_req_valid;
   logic [39:0] i_req_vpn;
   logic [1:0]  o_req_done;
   logic        o_req_fault;
   logic        o_mem_req;
   logic [31:0] o_mem_addr;
   logic        i_mem_ack;
   logic [31:0] i_mem_rdata;
   logic        o_tlb_write_enable;
   logic [19:0] o_tlb_write_virtual_addr;
   logic [19:0] o_tlb_write_physical_addr;
   logic        o_busy;

   int n_chk = 0;
   int n_fail = 0;

   logic [31:0] m_ptbr;
   bit          m_rr;
   logic [1:0]  pend;
   logic [19:0] vpn_q [2];

   tlb_walk_controller dut (
      .clk                       (clk),
      .rst_n                     (rst_n),
      .i_ptbr_we                 (i_ptbr_we),
      .i_ptbr                    (i_ptbr),
      .i_req_valid               (i_req_valid),
      .i_req_vpn                 (i_req_vpn),
      .o_req_done                (o_req_done),
      .o_req_fault               (o_req_fault),
      .o_mem_req                 (o_mem_req),
      .o_mem_addr                (o_mem_addr),
      .i_mem_ack                 (i_mem_ack),
      .i_mem_rdata               (i_mem_rdata),
      .o_tlb_write_enable        (o_tlb_write_enable),
      .o_tlb_write_virtual_addr  (o_tlb_write_virtual_addr),
      .o_tlb_write_physical_addr (o_tlb_write_physical_addr),
      .o_busy                    (o_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_reqs();
      i_req_valid = pend;
      i_req_vpn   = {vpn_q[1], vpn_q[0]};
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_mem_req"}, o_mem_req, 0);
      chk({tag, "_busy"}, o_busy, 0);
      chk({tag, "_addr"}, o_mem_addr, 0);
      chk({tag, "_done"}, o_req_done, 0);
      chk({tag, "_fault"}, o_req_fault, 0);
      chk({tag, "_we"}, o_tlb_write_enable, 0);
      chk({tag, "_va"}, o_tlb_write_virtual_addr, 0);
      chk({tag, "_pa"}, o_tlb_write_physical_addr, 0);
   endtask

   task automatic reset_dut();
      rst_n       = 1'b0;
      i_ptbr_we   = 1'b0;
      i_ptbr      = '0;
      i_mem_ack   = 1'b0;
      i_mem_rdata = '0;
      pend        = 2'b00;
      vpn_q[0]    = '0;
      vpn_q[1]    = '0;
      drive_reqs();
      step();
      step();
      chk_all_zero("rst");
      rst_n = 1'b1;
      step();
      m_ptbr = '0;
      m_rr   = 1'b0;
   endtask

   task automatic write_ptbr(input logic [31:0] v);
      i_ptbr_we = 1'b1;
      i_ptbr    = v;
      step();
      i_ptbr_we = 1'b0;
      m_ptbr    = v;
      chk("ptbr_idle_busy", o_busy, 0);
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         step();
         chk("idle_busy", o_busy, 0);
         chk("idle_mem_req", o_mem_req, 0);
         chk("idle_done", o_req_done, 0);
      end
   endtask

   // Starts in an IDLE cycle; returns in the IDLE cycle after the done pulse.
   task automatic do_walk(input logic [1:0] add, input logic [19:0] v0, input logic [19:0] v1,
                          input int delay, input logic [31:0] rdata,
                          input bit grant_we, input logic [31:0] grant_ptbr,
                          input bit mid_we, input logic [31:0] mid_ptbr);
      int          port;
      logic [63:0] sum;
      logic [31:0] exp_addr;
      logic [19:0] ev;
      logic [31:0] pte;
      bit          pte_ok;
      if (add[0] && !pend[0]) begin pend[0] = 1'b1; vpn_q[0] = v0; end
      if (add[1] && !pend[1]) begin pend[1] = 1'b1; vpn_q[1] = v1; end
      drive_reqs();
      if (pend == 2'b11) port = int'(m_rr);
      else if (pend[1])  port = 1;
      else               port = 0;
      ev       = vpn_q[port];
      sum      = 64'(m_ptbr) + 64'(ev) * 64'd4;
      exp_addr = sum[31:0];
      if (grant_we) begin
         i_ptbr_we = 1'b1;
         i_ptbr    = grant_ptbr;
         m_ptbr    = grant_ptbr;
      end
      step();
      i_ptbr_we = 1'b0;
      chk("req_start", o_mem_req, 1);
      chk("req_addr", o_mem_addr, exp_addr);
      chk("req_busy", o_busy, 1);
      chk("req_no_fill", o_tlb_write_enable, 0);
      for (int d = 0; d < delay; d++) begin
         if (d == 0 && mid_we) begin
            i_ptbr_we = 1'b1;
            i_ptbr    = mid_ptbr;
            m_ptbr    = mid_ptbr;
         end
         step();
         i_ptbr_we = 1'b0;
         chk("req_held", o_mem_req, 1);
         chk("addr_held", o_mem_addr, exp_addr);
         chk("stall_no_done", o_req_done, 0);
      end
      i_mem_ack   = 1'b1;
      i_mem_rdata = rdata;
      step();
      i_mem_ack   = 1'b0;
      i_mem_rdata = $urandom;
      pte         = rdata;
      pte_ok      = (pte % 2) == 1;
      if (pte_ok) begin
         chk("fill_we", o_tlb_write_enable, 1);
         chk("fill_va", o_tlb_write_virtual_addr, ev);
         chk("fill_pa", o_tlb_write_physical_addr, (pte / 2) % (1 << 20));
         chk("fill_mem_req", o_mem_req, 0);
         chk("fill_no_done", o_req_done, 0);
         step();
      end
      chk("done", o_req_done, (port == 1) ? 2'b10 : 2'b01);
      chk("done_fault", o_req_fault, !pte_ok);
      chk("resp_no_fill", o_tlb_write_enable, 0);
      chk("resp_mem_req", o_mem_req, 0);
      pend[port] = 1'b0;
      drive_reqs();
      m_rr = (port == 0);
      step();
      chk("done_pulse", o_req_done, 0);
      chk("fault_low", o_req_fault, 0);
      chk("idle_busy_after", o_busy, 0);
      chk("idle_no_fill", o_tlb_write_enable, 0);
   endtask

   initial begin
      logic [1:0]  add;
      logic [31:0] rd;
      reset_dut();

      // basic fill: addr 0x1014, va 0x5, pa 0x55
      write_ptbr(32'h0000_1000);
      do_walk(2'b01, 20'h00005, 20'h0, 0, 32'h0000_00AB, 0, 0, 0, 0);

      // fault on port 1
      do_walk(2'b10, 20'h0, 20'h00010, 0, 32'h0000_0000, 0, 0, 0, 0);

      // round-robin from reset
      reset_dut();
      do_walk(2'b11, 20'h00111, 20'h00222, 1, 32'h0000_1001, 0, 0, 0, 0);
      do_walk(2'b00, 20'h0, 20'h0, 0, 32'h0000_2003, 0, 0, 0, 0);
      do_walk(2'b11, 20'h00333, 20'h00444, 2, 32'h0000_0002, 0, 0, 0, 0);
      do_walk(2'b00, 20'h0, 20'h0, 0, 32'hFFFF_FFFF, 0, 0, 0, 0);

      // stalled memory with mid-walk ptbr write, then ptbr write at grant
      write_ptbr(32'h0000_2000);
      do_walk(2'b01, 20'h00007, 20'h0, 5, 32'h0000_1235, 0, 0, 1, 32'hDEAD_0000);
      do_walk(2'b10, 20'h0, 20'h00009, 2, 32'h0000_0777, 1, 32'h0000_5000, 0, 0);

      // address wrap: 0xFFFF_FFF0 + 0x20 -> 0x10
      write_ptbr(32'hFFFF_FFF0);
      do_walk(2'b01, 20'h00008, 20'h0, 0, 32'h0000_0003, 0, 0, 0, 0);

      // reset during REQ, late ack afterwards
      pend     = 2'b01;
      vpn_q[0] = 20'h00042;
      drive_reqs();
      step();
      chk("rst_pre_req", o_mem_req, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk_all_zero("rst_async");
      pend = 2'b00;
      drive_reqs();
      step();
      step();
      rst_n = 1'b1;
      step();
      i_mem_ack   = 1'b1;
      i_mem_rdata = 32'h0000_0101;
      step();
      i_mem_ack = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("late_ack_no_fill", o_tlb_write_enable, 0);
         chk("late_ack_no_done", o_req_done, 0);
         chk("late_ack_idle", o_busy, 0);
         chk("late_ack_no_req", o_mem_req, 0);
         step();
      end
      m_ptbr = '0;
      m_rr   = 1'b0;
      // rr and ptbr must both be back at reset values
      do_walk(2'b11, 20'h00050, 20'h00060, 0, 32'h0000_0011, 0, 0, 0, 0);
      do_walk(2'b00, 20'h0, 20'h0, 1, 32'h0000_0000, 0, 0, 0, 0);

      // randomized traffic
      for (int it = 0; it < 150; it++) begin
         add = 2'($urandom_range(0, 3));
         if (pend == 2'b00 && add == 2'b00) begin
            idle_cycles(int'($urandom_range(1, 3)));
            add = 2'($urandom_range(1, 3));
         end
         rd = $urandom;
         if ($urandom_range(0, 9) < 7) rd = rd | 32'h1;
         else                          rd = rd & ~32'h1;
         do_walk(add, 20'($urandom), 20'($urandom), int'($urandom_range(0, 4)), rd,
                 ($urandom_range(0, 7) == 0), $urandom,
                 ($urandom_range(0, 3) == 0), $urandom);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
